// File: rtl/cpu_tb_pkg.sv
// Shared types for the instruction-side test infrastructure around the CPU.
package cpu_tb_pkg;
    typedef logic [31:0] inst_t;
    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} streamer_state_e;
    localparam inst_t INST_ZERO = 32'h0;
endpackage

// File: rtl/inst_buf.sv
// DEPTH x 32 instruction store: one write port, one synchronous read port with a clear.
module inst_buf
    import cpu_tb_pkg::*;
#(
    parameter int DEPTH  = 64,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  inst_t             wr_data,
    input  logic              rd_en,
    input  logic              rd_clr,
    input  logic [ADDR_W-1:0] rd_addr,
    output inst_t             rd_data
);
    inst_t mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_addr] <= wr_data;
    end

    // The read register doubles as the streamer's instruction output, so clear wins over read.
    always_ff @(posedge clk) begin
        if (rd_clr)     rd_data <= INST_ZERO;
        else if (rd_en) rd_data <= mem[rd_addr];
    end
endmodule

// File: rtl/inst_streamer.sv
// Loads a program into a buffer, then streams it to the CPU honouring stalls, followed by a zero drain.
module inst_streamer
    import cpu_tb_pkg::*;
#(
    parameter int DEPTH        = 64,
    parameter int ADDR_W       = $clog2(DEPTH),
    parameter int DRAIN_CYCLES = 10
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_load_valid,
    input  inst_t           i_load_inst,
    output logic            o_load_ready,
    input  logic            i_go,
    input  logic            i_stall,
    output logic            o_start,
    output inst_t           o_inst,
    output logic            o_busy,
    output logic            o_done,
    output logic [ADDR_W:0] o_count
);
    localparam int DW = $clog2(DRAIN_CYCLES + 1);
    localparam logic [ADDR_W:0] FULL       = (ADDR_W + 1)'(DEPTH);
    localparam logic [DW-1:0]   DRAIN_LAST = DW'(DRAIN_CYCLES);

    streamer_state_e  state;
    logic [ADDR_W:0]  rd_ptr;
    logic [ADDR_W:0]  count_inc;
    logic [DW-1:0]    drain_cnt;
    logic             idle_or_done;
    logic             go_accept;
    logic             run_end;
    logic             wr_en;
    logic             rd_en;
    logic             rd_clr;
    logic [ADDR_W-1:0] wr_addr;

    always_comb begin
        idle_or_done = (state == IDLE) || (state == DONE);
        count_inc    = o_count + 1'b1;
        go_accept    = idle_or_done && !i_load_valid && i_go;
        run_end      = (state == RUN) && !i_stall && (rd_ptr == o_count);
        wr_en        = !i_rst && idle_or_done && i_load_valid && o_load_ready;
        // A load in DONE starts a fresh program at address 0.
        wr_addr      = (state == DONE) ? '0 : o_count[ADDR_W-1:0];
        rd_en        = (state == RUN) && !i_stall && (rd_ptr != o_count);
        rd_clr       = i_rst || run_end || go_accept;
    end

    inst_buf #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_buf (
        .clk     (i_clk),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (i_load_inst),
        .rd_en   (rd_en),
        .rd_clr  (rd_clr),
        .rd_addr (rd_ptr[ADDR_W-1:0]),
        .rd_data (o_inst)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state        <= IDLE;
            o_start      <= 1'b0;
            o_busy       <= 1'b0;
            o_done       <= 1'b0;
            o_count      <= '0;
            o_load_ready <= 1'b1;
            rd_ptr       <= '0;
            drain_cnt    <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (i_load_valid) begin
                        if (o_load_ready) begin
                            if (state == DONE) begin
                                o_count      <= (ADDR_W + 1)'(1);
                                o_done       <= 1'b0;
                                o_load_ready <= 1'b1;
                                state        <= IDLE;
                            end else begin
                                o_count      <= count_inc;
                                o_load_ready <= (count_inc != FULL);
                            end
                        end
                    end else if (i_go) begin
                        o_start      <= 1'b1;
                        o_busy       <= 1'b1;
                        o_done       <= 1'b0;
                        o_load_ready <= 1'b0;
                        rd_ptr       <= '0;
                        if (o_count != '0) begin
                            state <= RUN;
                        end else begin
                            state     <= DRAIN;
                            drain_cnt <= DW'(1);
                        end
                    end
                end
                RUN: begin
                    if (!i_stall) begin
                        if (rd_ptr == o_count) begin
                            state     <= DRAIN;
                            drain_cnt <= DW'(1);
                        end else begin
                            rd_ptr <= rd_ptr + 1'b1;
                        end
                    end
                end
                DRAIN: begin
                    if (!i_stall) begin
                        if (drain_cnt == DRAIN_LAST) begin
                            state        <= DONE;
                            o_start      <= 1'b0;
                            o_busy       <= 1'b0;
                            o_done       <= 1'b1;
                            o_load_ready <= (o_count != FULL);
                        end else begin
                            drain_cnt <= drain_cnt + 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_inst_streamer.sv
// Directed bench for inst_streamer: load, stream, stall, overflow, empty run, reset and replay.
module tb_inst_streamer;
    localparam int DEPTH  = 8;
    localparam int ADDR_W = 3;
    localparam int DRAIN  = 10;

    logic              clk = 1'b0;
    logic              rst;
    logic              load_valid;
    logic [31:0]       load_inst;
    logic              load_ready;
    logic              go;
    logic              stall;
    logic              start;
    logic [31:0]       inst;
    logic              busy;
    logic              done;
    logic [ADDR_W:0]   count;

    int checks   = 0;
    int failures = 0;

    logic [31:0] prog [3] = '{32'h00500093, 32'h00A00113, 32'h002081B3};

    inst_streamer #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DRAIN_CYCLES(DRAIN)) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_load_valid (load_valid),
        .i_load_inst  (load_inst),
        .o_load_ready (load_ready),
        .i_go         (go),
        .i_stall      (stall),
        .o_start      (start),
        .o_inst       (inst),
        .o_busy       (busy),
        .o_done       (done),
        .o_count      (count)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_start"}, 32'(start), 32'd0);
        chk({tag, "_inst"},  inst, 32'd0);
        chk({tag, "_busy"},  32'(busy), 32'd0);
        chk({tag, "_done"},  32'(done), 32'd0);
        chk({tag, "_count"}, 32'(count), 32'd0);
        chk({tag, "_ready"}, 32'(load_ready), 32'd1);
    endtask

    task automatic load_prog();
        load_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            load_inst = prog[i];
            step();
        end
        load_valid = 1'b0;
    endtask

    task automatic pulse_go();
        go = 1'b1;
        step();
        go = 1'b0;
    endtask

    // Expects the 3-word program to stream unstalled: 3 words, 10 zeros, done 14 cycles after start.
    task automatic expect_clean_run(input string tag);
        chk({tag, "_c0_start"}, 32'(start), 32'd1);
        chk({tag, "_c0_inst"},  inst, 32'd0);
        chk({tag, "_c0_busy"},  32'(busy), 32'd1);
        for (int i = 0; i < 3; i++) begin
            step();
            chk({tag, "_word"}, inst, prog[i]);
        end
        for (int i = 0; i < DRAIN; i++) begin
            step();
            chk({tag, "_drain_inst"},  inst, 32'd0);
            chk({tag, "_drain_start"}, 32'(start), 32'd1);
            chk({tag, "_drain_done"},  32'(done), 32'd0);
        end
        step();
        chk({tag, "_done"},       32'(done), 32'd1);
        chk({tag, "_done_start"}, 32'(start), 32'd0);
        chk({tag, "_done_busy"},  32'(busy), 32'd0);
    endtask

    initial begin
        rst = 1'b1; load_valid = 1'b0; load_inst = '0; go = 1'b0; stall = 1'b0;
        step();
        step();
        rst = 1'b0;
        chk_reset_vals("reset");

        // Test 1: load three words and stream them
        load_prog();
        chk("t1_count", 32'(count), 32'd3);
        chk("t1_ready", 32'(load_ready), 32'd1);
        pulse_go();
        expect_clean_run("t1");

        // Test 6a: replay from DONE
        pulse_go();
        expect_clean_run("t6_replay");

        // Test 2: stall two cycles while the second word is presented
        pulse_go();
        chk("t2_c0_start", 32'(start), 32'd1);
        step();
        chk("t2_c1", inst, prog[0]);
        step();
        chk("t2_c2", inst, prog[1]);
        stall = 1'b1;
        step();
        chk("t2_c3_hold", inst, prog[1]);
        step();
        chk("t2_c4_hold", inst, prog[1]);
        stall = 1'b0;
        step();
        chk("t2_c5", inst, prog[2]);
        for (int k = 6; k <= 16; k++) begin
            step();
            chk("t2_done_timing", 32'(done), (k == 16) ? 32'd1 : 32'd0);
            chk("t2_inst_zero", inst, 32'd0);
        end

        // Test 6b: a new load in DONE restarts the program
        load_valid = 1'b1;
        load_inst  = 32'h00000013;
        step();
        load_valid = 1'b0;
        chk("t6_count", 32'(count), 32'd1);
        chk("t6_done",  32'(done), 32'd0);
        chk("t6_ready", 32'(load_ready), 32'd1);

        // Test 3: overflow the buffer by two words
        rst = 1'b1;
        step();
        rst = 1'b0;
        load_valid = 1'b1;
        for (int i = 0; i < DEPTH + 2; i++) begin
            load_inst = 32'h1000 + 32'(i);
            step();
            chk("t3_count", 32'(count), (i < DEPTH) ? 32'(i + 1) : 32'(DEPTH));
            chk("t3_ready", 32'(load_ready), (i < DEPTH - 1) ? 32'd1 : 32'd0);
        end
        load_valid = 1'b0;
        pulse_go();
        chk("t3_c0_start", 32'(start), 32'd1);
        for (int i = 0; i < DEPTH; i++) begin
            step();
            chk("t3_word", inst, 32'h1000 + 32'(i));
        end
        step();
        chk("t3_drain_inst", inst, 32'd0);
        chk("t3_drain_busy", 32'(busy), 32'd1);
        for (int i = 1; i < DRAIN; i++) step();
        chk("t3_pre_done", 32'(done), 32'd0);
        step();
        chk("t3_done", 32'(done), 32'd1);

        // Test 5: reset in the middle of a run
        rst = 1'b1;
        step();
        rst = 1'b0;
        load_prog();
        pulse_go();
        step();
        step();
        chk("t5_pre_rst", inst, prog[1]);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk_reset_vals("t5_rst");

        // Test 4: go with an empty buffer
        pulse_go();
        for (int i = 0; i < DRAIN; i++) begin
            chk("t4_start", 32'(start), 32'd1);
            chk("t4_inst",  inst, 32'd0);
            chk("t4_busy",  32'(busy), 32'd1);
            chk("t4_done",  32'(done), 32'd0);
            step();
        end
        chk("t4_final_done",  32'(done), 32'd1);
        chk("t4_final_start", 32'(start), 32'd0);
        chk("t4_final_busy",  32'(busy), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule
